// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-requester ALU arbiter.
// Requester indices never exceed 3 bits because NUM_REQ is at most 8.
package alu_pkg;

   localparam int ALU_W       = 4;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_TIMEOUT = 15;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   typedef logic [ALU_W-1:0] alu_ctl_t;

   localparam alu_ctl_t CTL_AND = 4'h0;
   localparam alu_ctl_t CTL_OR  = 4'h1;
   localparam alu_ctl_t CTL_ADD = 4'h2;
   localparam alu_ctl_t CTL_SUB = 4'h6;

   // (a + b) mod n for a < n and b <= n.
   function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                            input int unsigned n);
      int unsigned s;
      s = a + b;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: scans req ascending from ptr (mod NUM_REQ) and returns the
// first hit as a one-hot grant plus its index.
module rr_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               found
);

   logic [IDX_W-1:0] k;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      k         = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = IDX_W'(wrap_add(32'(ptr), i, NUM_REQ));
         if (!found && req[k]) begin
            found     = 1'b1;
            grant[k]  = 1'b1;
            grant_idx = k;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, one operation in
// flight, per-requester carry flag, response timeout and spurious-return flag.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0][ALU_W-1:0]   req_a,
   input  logic [NUM_REQ-1:0][ALU_W-1:0]   req_b,
   input  alu_ctl_t [NUM_REQ-1:0]          req_ctl,
   input  logic [NUM_REQ-1:0]              req_use_cf,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [ALU_W-1:0]                rsp_alu,
   output logic                            rsp_carry,
   output logic                            rsp_zero,
   output logic                            rsp_timeout,
   output logic                            alu_valid_in,
   output logic                            alu_cin,
   output logic [ALU_W-1:0]                alu_a,
   output logic [ALU_W-1:0]                alu_b,
   output alu_ctl_t                        alu_ctl,
   input  logic                            alu_valid_out,
   input  logic                            alu_carry,
   input  logic                            alu_zero,
   input  logic [ALU_W-1:0]                alu_result,
   output logic [31:0]                     pkt_num,
   output logic                            err_spurious,
   output state_t                          dbg_state
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 8;

   state_t              state, next_state;
   logic [IDX_W-1:0]    rr_ptr, win_idx;
   logic [NUM_REQ-1:0]  grant;
   logic [IDX_W-1:0]    grant_idx;
   logic                any_req;
   logic [NUM_REQ-1:0]  carry_flag;
   logic [ALU_W-1:0]    lat_a, lat_b;
   alu_ctl_t            lat_ctl;
   logic                lat_cin;
   logic [ALU_W-1:0]    cap_res;
   logic                cap_carry, cap_zero, cap_tmo;
   logic [CNT_W-1:0]    cnt, cnt_inc;
   logic                cnt_hit;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .found     (any_req)
   );

   assign cnt_inc = cnt + CNT_W'(1);
   assign cnt_hit = (cnt_inc == CNT_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (any_req) next_state = S_ISSUE;
         S_ISSUE: next_state = S_WAIT;
         S_WAIT:  if (alu_valid_out || cnt_hit) next_state = S_RESP;
         S_RESP:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // A result arriving on the very cycle the counter expires still wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr       <= '0;
         win_idx      <= '0;
         carry_flag   <= '0;
         lat_a        <= '0;
         lat_b        <= '0;
         lat_ctl      <= '0;
         lat_cin      <= 1'b0;
         cap_res      <= '0;
         cap_carry    <= 1'b0;
         cap_zero     <= 1'b0;
         cap_tmo      <= 1'b0;
         cnt          <= '0;
         pkt_num      <= '0;
         err_spurious <= 1'b0;
      end else begin
         if (alu_valid_out && state != S_WAIT) err_spurious <= 1'b1;
         case (state)
            S_IDLE: if (any_req) begin
               win_idx <= grant_idx;
               lat_a   <= req_a[grant_idx];
               lat_b   <= req_b[grant_idx];
               lat_ctl <= req_ctl[grant_idx];
               lat_cin <= req_use_cf[grant_idx] & carry_flag[grant_idx];
            end
            S_ISSUE: begin
               pkt_num <= pkt_num + 32'd1;
               cnt     <= '0;
            end
            S_WAIT: begin
               if (alu_valid_out) begin
                  cap_res   <= alu_result;
                  cap_carry <= alu_carry;
                  cap_zero  <= alu_zero;
                  cap_tmo   <= 1'b0;
               end else if (cnt_hit) begin
                  cap_res   <= '0;
                  cap_carry <= 1'b0;
                  cap_zero  <= 1'b0;
                  cap_tmo   <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_RESP: begin
               if (!cap_tmo) carry_flag[win_idx] <= cap_carry;
               rr_ptr <= IDX_W'(wrap_add(32'(win_idx), 1, NUM_REQ));
            end
            default: ;
         endcase
      end
   end

   // Handshake: a request is taken on a rising edge where req_valid[i] and
   // req_ready[i] are both high; req_ready is only ever raised in IDLE, for
   // the round-robin winner, and the response is a one-cycle rsp_valid pulse.
   always_comb begin
      req_ready    = (state == S_IDLE) ? grant : '0;
      alu_valid_in = (state == S_ISSUE);
      alu_a        = lat_a;
      alu_b        = lat_b;
      alu_ctl      = lat_ctl;
      alu_cin      = lat_cin;
      rsp_valid    = '0;
      rsp_alu      = '0;
      rsp_carry    = 1'b0;
      rsp_zero     = 1'b0;
      rsp_timeout  = 1'b0;
      if (state == S_RESP) begin
         rsp_valid   = NUM_REQ'(1) << win_idx;
         rsp_alu     = cap_res;
         rsp_carry   = cap_carry;
         rsp_zero    = cap_zero;
         rsp_timeout = cap_tmo;
      end
   end

   assign dbg_state = state;

endmodule
